mem_stall_ctrl: RTL and testbench

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

---
 rtl/mem_stall_pkg.sv | 21 ++
 rtl/stall_ch_tracker.sv | 76 +++++++
 rtl/mem_stall_ctrl.sv | 116 +++++++++++
 tb/tb_mem_stall_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stall_pkg.sv
// Shared types and parameter defaults for the memory stall controller.
// Holds the FSM state encoding and the age-counter width helper.
package mem_stall_pkg;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_MAX_OUTST = 4;
    localparam int DEF_TIMEOUT   = 255;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // A disabled timeout (0) still needs a 1-bit age register.
    function automatic int age_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/stall_ch_tracker.sv
// One memory channel: outstanding-request count, response age and spurious flag.
// Reports next-cycle fullness, emptiness and timeout to the controlling FSM.
module stall_ch_tracker
    import mem_stall_pkg::*;
#(
    parameter int MAX_OUTST = DEF_MAX_OUTST,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int CNT_W     = $clog2(DEF_MAX_OUTST + 1),
    parameter int AGE_W     = age_width(DEF_TIMEOUT)
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_issue,
    input  logic             i_rvalid,
    input  logic             i_age_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_req_ok,
    output logic             o_full_next,
    output logic             o_empty,
    output logic             o_age_hit,
    output logic             o_spurious
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic [AGE_W-1:0] r_age;
    logic             r_spurious;
    logic [CNT_W-1:0] w_cnt_next;
    logic [AGE_W-1:0] w_age_next;
    logic             w_empty;
    logic             w_full;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CNT_MAX);

    // Simultaneous issue and response cancel out; boundary cases saturate.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_issue && !i_rvalid && !w_full) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else if (!i_issue && i_rvalid && !w_empty) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        w_age_next = r_age;
        if (i_age_clr || i_rvalid || w_empty) begin
            w_age_next = '0;
        end else if (r_age != AGE_MAX) begin
            w_age_next = r_age + AGE_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_cnt      <= '0;
            r_age      <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_age      <= w_age_next;
            r_spurious <= r_spurious | (i_rvalid & w_empty);
        end
    end

    assign o_cnt       = r_cnt;
    assign o_req_ok    = !w_full;
    assign o_full_next = (w_cnt_next == CNT_MAX);
    assign o_empty     = w_empty;
    assign o_age_hit   = (TIMEOUT != 0) && (w_age_next == AGE_MAX);
    assign o_spurious  = r_spurious;

endmodule

// File: rtl/mem_stall_ctrl.sv
// Pipeline stall controller: gates PC updates on per-channel outstanding requests,
// flush draining and response timeouts.
module mem_stall_ctrl
    import mem_stall_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int MAX_OUTST = DEF_MAX_OUTST,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    localparam int CNT_W    = $clog2(MAX_OUTST + 1),
    localparam int AGE_W    = age_width(TIMEOUT)
) (
    input  logic                    i_clk,
    input  logic                    i_resetn,
    input  logic                    i_we,
    input  logic                    i_flush,
    input  logic                    i_err_clr,
    input  logic [NUM_CH-1:0]       i_req,
    input  logic [NUM_CH-1:0]       i_gnt,
    input  logic [NUM_CH-1:0]       i_rvalid,
    output logic                    o_en_pc,
    output logic [NUM_CH-1:0]       o_req_ok,
    output logic [NUM_CH*CNT_W-1:0] o_cnt,
    output logic                    o_timeout,
    output logic                    o_spurious
);

    state_e            r_state;
    state_e            w_state_next;
    logic              r_en_pc;
    logic              r_timeout;
    logic              w_en_pc_next;
    logic              w_timeout_next;
    logic              w_age_clr;
    logic [NUM_CH-1:0] w_full_next;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_age_hit;
    logic [NUM_CH-1:0] w_spurious;

    assign w_age_clr = (r_state == ST_ERR) && i_err_clr;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            stall_ch_tracker #(
                .MAX_OUTST (MAX_OUTST),
                .TIMEOUT   (TIMEOUT),
                .CNT_W     (CNT_W),
                .AGE_W     (AGE_W)
            ) u_trk (
                .i_clk       (i_clk),
                .i_resetn    (i_resetn),
                .i_issue     (i_req[gi] & i_gnt[gi]),
                .i_rvalid    (i_rvalid[gi]),
                .i_age_clr   (w_age_clr),
                .o_cnt       (o_cnt[gi*CNT_W +: CNT_W]),
                .o_req_ok    (o_req_ok[gi]),
                .o_full_next (w_full_next[gi]),
                .o_empty     (w_empty[gi]),
                .o_age_hit   (w_age_hit[gi]),
                .o_spurious  (w_spurious[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state   <= ST_RUN;
            r_en_pc   <= 1'b1;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_en_pc   <= w_en_pc_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Timeout outranks everything, flush outranks a stall entry.
    always_comb begin
        w_state_next = r_state;
        if (|w_age_hit) begin
            w_state_next = ST_ERR;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_flush)           w_state_next = ST_DRAIN;
                    else if (|w_full_next) w_state_next = ST_STALL;
                end
                ST_STALL: begin
                    if (i_flush)            w_state_next = ST_DRAIN;
                    else if (!(|w_full_next)) w_state_next = ST_RUN;
                end
                ST_DRAIN: begin
                    if (&w_empty) w_state_next = ST_RUN;
                end
                ST_ERR: begin
                    if (i_err_clr) w_state_next = ST_DRAIN;
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        w_en_pc_next   = (w_state_next == ST_RUN) && i_we;
        w_timeout_next = r_timeout;
        if (|w_age_hit) begin
            w_timeout_next = 1'b1;
        end else if (w_age_clr) begin
            w_timeout_next = 1'b0;
        end
    end

    assign o_en_pc    = r_en_pc;
    assign o_timeout  = r_timeout;
    assign o_spurious = |w_spurious;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_mem_stall_ctrl;

    localparam int NCH  = 2;
    localparam int MAXO = 4;
    localparam int TO   = 8;
    localparam int CW   = $clog2(MAXO + 1);

    localparam int S_RUN = 0, S_STALL = 1, S_DRAIN = 2, S_ERR = 3;

    logic              clk = 1'b0;
    logic              resetn, we, flush, err_clr;
    logic [NCH-1:0]    req, gnt, rvalid;
    logic              en_pc, timeout, spurious;
    logic [NCH-1:0]    req_ok;
    logic [NCH*CW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_cnt [NCH];
    int m_age [NCH];
    int m_state;
    bit m_en, m_to, m_sp;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.NUM_CH(NCH), .MAX_OUTST(MAXO), .TIMEOUT(TO)) dut (
        .i_clk     (clk),
        .i_resetn  (resetn),
        .i_we      (we),
        .i_flush   (flush),
        .i_err_clr (err_clr),
        .i_req     (req),
        .i_gnt     (gnt),
        .i_rvalid  (rvalid),
        .o_en_pc   (en_pc),
        .o_req_ok  (req_ok),
        .o_cnt     (cnt),
        .o_timeout (timeout),
        .o_spurious(spurious)
    );

    function automatic int dut_cnt(input int ch);
        return int'(cnt[ch*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_cnt[ch] = 0;
            m_age[ch] = 0;
        end
        m_state = S_RUN;
        m_en = 1'b1;
        m_to = 1'b0;
        m_sp = 1'b0;
    endtask

    // One clock of the rules: counts, ages, then the mode transition.
    task automatic model_step(input logic [NCH-1:0] rq, input logic [NCH-1:0] gt,
                              input logic [NCH-1:0] rv, input logic fl,
                              input logic w, input logic cl);
        int nc [NCH];
        int na [NCH];
        bit hit, any_full, all_empty, clr_all, iss;
        int ns;
        hit = 0; any_full = 0; all_empty = 1;
        clr_all = (m_state == S_ERR) && cl;
        for (int ch = 0; ch < NCH; ch++) begin
            iss = rq[ch] & gt[ch];
            nc[ch] = m_cnt[ch];
            if (rv[ch] && m_cnt[ch] == 0) m_sp = 1'b1;
            if (iss && !rv[ch]) nc[ch] = (m_cnt[ch] < MAXO) ? m_cnt[ch] + 1 : m_cnt[ch];
            else if (!iss && rv[ch] && m_cnt[ch] > 0) nc[ch] = m_cnt[ch] - 1;
            if (clr_all || rv[ch] || m_cnt[ch] == 0) na[ch] = 0;
            else na[ch] = (m_age[ch] < TO) ? m_age[ch] + 1 : TO;
            if (TO != 0 && na[ch] == TO) hit = 1;
            if (nc[ch] == MAXO) any_full = 1;
            if (m_cnt[ch] != 0) all_empty = 0;
        end
        ns = m_state;
        if (hit) ns = S_ERR;
        else if (m_state == S_RUN)   ns = fl ? S_DRAIN : (any_full ? S_STALL : S_RUN);
        else if (m_state == S_STALL) ns = fl ? S_DRAIN : (any_full ? S_STALL : S_RUN);
        else if (m_state == S_DRAIN) ns = all_empty ? S_RUN : S_DRAIN;
        else                         ns = cl ? S_DRAIN : S_ERR;
        if (hit) m_to = 1'b1;
        else if (clr_all) m_to = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_cnt[ch] = nc[ch];
            m_age[ch] = na[ch];
        end
        m_state = ns;
        m_en = (ns == S_RUN) && w;
    endtask

    task automatic cycle(input logic [NCH-1:0] rq, input logic [NCH-1:0] gt,
                         input logic [NCH-1:0] rv, input logic fl,
                         input logic w, input logic cl);
        req = rq; gnt = gt; rvalid = rv; flush = fl; we = w; err_clr = cl;
        model_step(rq, gt, rv, fl, w, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = '0; gnt = '0; rvalid = '0; flush = 1'b0; we = 1'b1; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (en_pc !== 1'b1) begin errors++; $display("FAIL reset_en_pc got %b exp 1", en_pc); end
        checks++;
        if (cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h exp 0", cnt); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
        checks++;
        if (spurious !== 1'b0) begin errors++; $display("FAIL reset_spurious got %b exp 0", spurious); end
        $display("test_reset done");
    endtask

    task automatic test_idle();
        for (int k = 0; k < 5; k++) begin
            cycle(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
            checks++;
            if (en_pc !== 1'b1 || cnt !== '0) begin
                errors++; $display("FAIL idle cyc %0d en_pc %b cnt %h exp 1/0", k, en_pc, cnt);
            end
        end
        $display("test_idle done");
    endtask

    task automatic test_stall();
        for (int k = 1; k <= 4; k++) begin
            cycle(2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
            checks++;
            if (dut_cnt(1) !== k) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", dut_cnt(1), k); end
            checks++;
            if (en_pc !== (k < 4)) begin errors++; $display("FAIL stall_en_pc k=%0d got %b exp %b", k, en_pc, k < 4); end
        end
        checks++;
        if (req_ok[1] !== 1'b0) begin errors++; $display("FAIL stall_req_ok got %b exp 0", req_ok[1]); end
        cycle(2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_cnt(1) !== MAXO) begin errors++; $display("FAIL stall_sat got %0d exp %0d", dut_cnt(1), MAXO); end
        cycle(2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_cnt(1) !== 3 || en_pc !== 1'b1) begin
            errors++; $display("FAIL stall_release cnt %0d en_pc %b exp 3/1", dut_cnt(1), en_pc);
        end
        repeat (3) cycle(2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_cnt(1) !== 0) begin errors++; $display("FAIL stall_drain got %0d exp 0", dut_cnt(1)); end
        $display("test_stall done");
    endtask

    task automatic test_concurrent();
        repeat (2) cycle(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
            checks++;
            if (dut_cnt(0) !== 2 || en_pc !== 1'b1) begin
                errors++; $display("FAIL concurrent cyc %0d cnt %0d en_pc %b exp 2/1", k, dut_cnt(0), en_pc);
            end
        end
        repeat (2) cycle(2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_cnt(0) !== 0) begin errors++; $display("FAIL concurrent_drain got %0d exp 0", dut_cnt(0)); end
        $display("test_concurrent done");
    endtask

    task automatic test_flush();
        repeat (3) cycle(2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
        cycle(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        checks++;
        if (en_pc !== 1'b0 || dut_cnt(1) !== 3) begin
            errors++; $display("FAIL flush_enter en_pc %b cnt %0d exp 0/3", en_pc, dut_cnt(1));
        end
        for (int k = 2; k >= 0; k--) begin
            cycle(2'b00, 2'b00, 2'b10, (k == 2), 1'b1, 1'b0);
            checks++;
            if (en_pc !== 1'b0 || dut_cnt(1) !== k) begin
                errors++; $display("FAIL flush_drain en_pc %b cnt %0d exp 0/%0d", en_pc, dut_cnt(1), k);
            end
        end
        cycle(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (en_pc !== 1'b1) begin errors++; $display("FAIL flush_exit en_pc got %b exp 1", en_pc); end
        $display("test_flush done");
    endtask

    task automatic test_timeout();
        cycle(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            cycle(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
            checks++;
            if (timeout !== (k == TO) || en_pc !== (k < TO)) begin
                errors++; $display("FAIL timeout cyc %0d timeout %b en_pc %b exp %b/%b", k, timeout, en_pc, k == TO, k < TO);
            end
        end
        cycle(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        checks++;
        if (timeout !== 1'b0 || en_pc !== 1'b0 || dut_cnt(0) !== 1) begin
            errors++; $display("FAIL err_clr timeout %b en_pc %b cnt %0d exp 0/0/1", timeout, en_pc, dut_cnt(0));
        end
        cycle(2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_cnt(0) !== 0 || en_pc !== 1'b0) begin
            errors++; $display("FAIL err_drain cnt %0d en_pc %b exp 0/0", dut_cnt(0), en_pc);
        end
        cycle(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (en_pc !== 1'b1) begin errors++; $display("FAIL err_run en_pc got %b exp 1", en_pc); end
        $display("test_timeout done");
    endtask

    task automatic test_spurious();
        checks++;
        if (spurious !== 1'b0) begin errors++; $display("FAIL spur_pre got %b exp 0", spurious); end
        cycle(2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0);
        checks++;
        if (spurious !== 1'b1 || dut_cnt(1) !== 0) begin
            errors++; $display("FAIL spur_set sp %b cnt %0d exp 1/0", spurious, dut_cnt(1));
        end
        repeat (3) cycle(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (spurious !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", spurious); end
        repeat (2) cycle(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        do_reset();
        checks++;
        if (dut_cnt(0) !== 0 || spurious !== 1'b0) begin
            errors++; $display("FAIL midreset cnt %0d sp %b exp 0/0", dut_cnt(0), spurious);
        end
        cycle(2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        checks++;
        if (spurious !== 1'b1 || dut_cnt(0) !== 0) begin
            errors++; $display("FAIL post_reset_rv sp %b cnt %0d exp 1/0", spurious, dut_cnt(0));
        end
        $display("test_spurious done");
    endtask

    task automatic test_random();
        logic [NCH-1:0] rq, gt, rv;
        logic fl, w, cl;
        int bad;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            rq = NCH'($urandom);
            gt = NCH'($urandom);
            for (int ch = 0; ch < NCH; ch++) rv[ch] = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 15) == 0);
            cl = ($urandom_range(0, 7) == 0);
            w  = ($urandom_range(0, 3) != 0);
            cycle(rq, gt, rv, fl, w, cl);
            bad = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                checks++;
                if (dut_cnt(ch) !== m_cnt[ch] || req_ok[ch] !== (m_cnt[ch] < MAXO)) begin
                    errors++; bad = 1;
                    $display("FAIL rand_cnt n=%0d ch%0d cnt %0d ok %b exp %0d/%b", n, ch, dut_cnt(ch), req_ok[ch], m_cnt[ch], m_cnt[ch] < MAXO);
                end
            end
            checks++;
            if (en_pc !== m_en || timeout !== m_to || spurious !== m_sp) begin
                errors++; bad = 1;
                $display("FAIL rand_flags n=%0d en %b to %b sp %b exp %b/%b/%b", n, en_pc, timeout, spurious, m_en, m_to, m_sp);
            end
            if (bad != 0) $display("rand n=%0d state_model=%0d", n, m_state);
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_stall();
        test_concurrent();
        test_flush();
        test_timeout();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
